udp_tx_arbiter: RTL

Packet-level round-robin arbiter that shares the single UDP transmit payload path between two byte-stream sources: the camera packetizer (source 0) and the test-pattern generator (source 1). It grants one source per packet, latches that packet's UDP length for the UDP/IP TX core, and forwards the granted source's bytes. It counts bytes to find the packet end, then enforces an inter-frame gap before re-arbitrating. It sits between the payload sources and the UDP TX core.

---
 rtl/udp_arb_pkg.sv | 25 ++
 rtl/udp_arb_rr.sv | 22 ++
 rtl/udp_tx_arbiter.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/udp_arb_pkg.sv
// Shared constants for the UDP TX payload arbiter: FSM encoding, default limits, source ids.
// Optional stall watchdog is enabled by defining UDP_ARB_TIMEOUT_EN.
package udp_arb_pkg;

    localparam int unsigned LEN_W  = 16;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned NSRC   = 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XFER = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam int unsigned IFG_DEF     = 12;
    localparam int unsigned MAX_LEN_DEF = 1472;
    localparam int unsigned TIMEOUT_DEF = 1024;

    localparam int unsigned SRC_CAM = 0;
    localparam int unsigned SRC_TPG = 1;

    // A UDP payload length is legal when non-zero and not above max_len.
    function automatic logic len_legal(input logic [LEN_W-1:0] len, input int unsigned max_len);
        return (len != '0) && (32'(len) <= max_len);
    endfunction

endpackage

// File: rtl/udp_arb_rr.sv
// Combinational 2-way round-robin picker; ptr_i names the source that wins a tie.
module udp_arb_rr
    import udp_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    output logic [1:0] win_o,
    output logic       win_idx_o
);

    always_comb begin
        win_idx_o = 1'(SRC_CAM);
        if (req_i[SRC_TPG] && (!req_i[SRC_CAM] || ptr_i)) begin
            win_idx_o = 1'(SRC_TPG);
        end
        win_o = '0;
        if (req_i != '0) begin
            win_o[win_idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/udp_tx_arbiter.sv
// Packet-level round-robin arbiter feeding the UDP TX core from two byte-stream sources.
// Define UDP_ARB_TIMEOUT_EN to enable the stall watchdog that aborts a stuck packet.
module udp_tx_arbiter
    import udp_arb_pkg::*;
#(
    parameter int unsigned IFG     = IFG_DEF,
    parameter int unsigned MAX_LEN = MAX_LEN_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic [LEN_W-1:0]  len0,
    input  logic [LEN_W-1:0]  len1,
    input  logic [DATA_W-1:0] data0,
    input  logic [DATA_W-1:0] data1,
    input  logic              valid0,
    input  logic              valid1,
    output logic [1:0]        gnt,
    output logic [1:0]        done,
    output logic [1:0]        err,
    input  logic              tx_ready,
    output logic              tx_start,
    output logic [LEN_W-1:0]  tx_udp_length,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    output logic              tx_abort
);

    logic [1:0]        state_q, state_d;
    logic              ptr_q, ptr_d;
    logic              idx_q, idx_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [LEN_W-1:0]  ifg_q, ifg_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [1:0]        done_q, done_d;
    logic [1:0]        err_q, err_d;
    logic              start_q, start_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;

    logic [1:0]        req_eff;
    logic [1:0]        win;
    logic              win_idx;
    logic [LEN_W-1:0]  win_len;
    logic              gv;
    logic [DATA_W-1:0] gdata;

    // A request is stale during its own done cycle; the source drops it afterwards.
    assign req_eff = req & ~done_q;
    assign win_len = win_idx ? len1 : len0;
    assign gv      = idx_q ? valid1 : valid0;
    assign gdata   = idx_q ? data1 : data0;

    udp_arb_rr u_rr (
        .req_i     (req_eff),
        .ptr_i     (ptr_q),
        .win_o     (win),
        .win_idx_o (win_idx)
    );

`ifdef UDP_ARB_TIMEOUT_EN
    localparam int unsigned STALL_W = $clog2(TIMEOUT + 1);
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               abort_q, abort_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^32'(TIMEOUT);
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        ifg_d   = ifg_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        err_d   = '0;
        start_d = 1'b0;
        len_d   = len_q;
        data_d  = data_q;
        valid_d = 1'b0;
`ifdef UDP_ARB_TIMEOUT_EN
        stall_d = stall_q;
        abort_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if ((req_eff != '0) && tx_ready) begin
                    ptr_d = ~win_idx;
                    if (len_legal(win_len, MAX_LEN)) begin
                        gnt_d   = win;
                        idx_d   = win_idx;
                        len_d   = win_len;
                        start_d = 1'b1;
                        cnt_d   = '0;
`ifdef UDP_ARB_TIMEOUT_EN
                        stall_d = '0;
`endif
                        state_d = ST_XFER;
                    end else begin
                        done_d = win;
                        err_d  = win;
                    end
                end
            end
            ST_XFER: begin
                if (gv) begin
                    valid_d = 1'b1;
                    data_d  = gdata;
                    cnt_d   = cnt_q + LEN_W'(1);
`ifdef UDP_ARB_TIMEOUT_EN
                    stall_d = '0;
`endif
                    if (cnt_q == len_q - LEN_W'(1)) begin
                        gnt_d   = '0;
                        done_d  = gnt_q;
                        ifg_d   = LEN_W'(IFG - 1);
                        state_d = ST_GAP;
                    end
                end
`ifdef UDP_ARB_TIMEOUT_EN
                else if (stall_q == STALL_W'(TIMEOUT - 1)) begin
                    abort_d = 1'b1;
                    gnt_d   = '0;
                    done_d  = gnt_q;
                    err_d   = gnt_q;
                    ifg_d   = LEN_W'(IFG - 1);
                    state_d = ST_GAP;
                end else begin
                    stall_d = stall_q + STALL_W'(1);
                end
`endif
            end
            ST_GAP: begin
                if (ifg_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    ifg_d = ifg_q - LEN_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= 1'(SRC_CAM);
            idx_q   <= 1'b0;
            cnt_q   <= '0;
            ifg_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= '0;
            start_q <= 1'b0;
            len_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
`ifdef UDP_ARB_TIMEOUT_EN
            stall_q <= '0;
            abort_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            ifg_q   <= ifg_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            start_q <= start_d;
            len_q   <= len_d;
            data_q  <= data_d;
            valid_q <= valid_d;
`ifdef UDP_ARB_TIMEOUT_EN
            stall_q <= stall_d;
            abort_q <= abort_d;
`endif
        end
    end

    assign gnt           = gnt_q;
    assign done          = done_q;
    assign err           = err_q;
    assign tx_start      = start_q;
    assign tx_udp_length = len_q;
    assign tx_data       = data_q;
    assign tx_valid      = valid_q;
`ifdef UDP_ARB_TIMEOUT_EN
    assign tx_abort      = abort_q;
`else
    assign tx_abort      = 1'b0;
`endif

endmodule
